// File: rtl/hamming_pkg.sv
// Shared constants, state encoding and the Hamming(21,16) encoder used by
// the encode scheduler.
package hamming_pkg;

    localparam int DATA_W = 16;
    localparam int CODE_W = 21;

    // Codeword positions (1-based) that carry parity
    localparam int P_POS1  = 1;
    localparam int P_POS2  = 2;
    localparam int P_POS4  = 4;
    localparam int P_POS8  = 8;
    localparam int P_POS16 = 16;
    localparam int N_PARITY = 5;

    localparam logic [CODE_W-1:0] PARITY_MASK =
        (CODE_W'(1) << (P_POS1 - 1)) | (CODE_W'(1) << (P_POS2 - 1)) |
        (CODE_W'(1) << (P_POS4 - 1)) | (CODE_W'(1) << (P_POS8 - 1)) |
        (CODE_W'(1) << (P_POS16 - 1));

    typedef enum logic {IDLE, BURST} state_t;

    // Data bits fill non-parity positions in ascending order; parity bit at
    // position 2^k is the even parity of every data position with bit k set.
    function automatic logic [CODE_W-1:0] ham_encode(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] code;
        logic              parity;
        int                dataIdx;
        int                tgt;
        code    = '0;
        dataIdx = 0;
        for (int b = 0; b < CODE_W; b++) begin
            if (!PARITY_MASK[b[4:0]]) begin
                code[b[4:0]] = data[dataIdx[3:0]];
                dataIdx++;
            end
        end
        for (int k = 0; k < N_PARITY; k++) begin
            parity = 1'b0;
            for (int b = 0; b < CODE_W; b++) begin
                if (!PARITY_MASK[b[4:0]] && (((b + 1) >> k) & 1) != 0)
                    parity ^= code[b[4:0]];
            end
            tgt = (1 << k) - 1;
            code[tgt[4:0]] = parity;
        end
        return code;
    endfunction

endpackage

// File: rtl/hamming_enc_sched_arb.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grantOh,
    output logic [W-1:0] grantIdx
);

    int idx;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        grantOh  = '0;
        grantIdx = '0;
        idx      = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx -= N;
            if (grantOh == '0 && req[idx[W-1:0]]) begin
                grantOh[idx[W-1:0]] = 1'b1;
                grantIdx            = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/hamming_enc_sched.sv
// Shares one Hamming(21,16) encoder among N_REQ requesters with round-robin
// grants of bounded burst length and a single valid/ready output slot.
module hamming_enc_sched
    import hamming_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int BURST_LEN = 4,
    localparam int SRC_W     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [CODE_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [15:0]             word_cnt
);

    state_t             state, nextState;
    logic [SRC_W-1:0]   grant, rrPtr, arbIdx;
    logic [N_REQ-1:0]   arbOh;
    logic [7:0]         burstCnt;
    logic [DATA_W-1:0]  grantData;
    logic               slotFree, grantValid, lastBeat, accept, releaseGrant;

    rr_arbiter #(.N(N_REQ)) uArb (
        .req      (req_valid),
        .ptr      (rrPtr),
        .grantOh  (arbOh),
        .grantIdx (arbIdx)
    );

    // The slot can take a word when empty or when it drains this same cycle
    assign slotFree   = !out_valid || out_ready;
    assign grantValid = req_valid[grant];
    assign grantData  = req_data[DATA_W*grant +: DATA_W];
    assign lastBeat   = (burstCnt == 8'(BURST_LEN - 1));
    assign busy       = (state != IDLE) || out_valid;

    always_comb begin
        nextState    = state;
        req_ready    = '0;
        accept       = 1'b0;
        releaseGrant = 1'b0;
        case (state)
            IDLE: begin
                if (|arbOh) nextState = BURST;
            end
            BURST: begin
                if (grantValid && slotFree) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                end
                // A stalled slot never releases; an idle requester only does so once the slot could accept
                releaseGrant = (accept && lastBeat) || (!grantValid && slotFree);
                if (releaseGrant) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rrPtr     <= '0;
            burstCnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            word_cnt  <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && |arbOh) begin
                grant    <= arbIdx;
                burstCnt <= '0;
            end
            if (accept) burstCnt <= burstCnt + 8'd1;
            if (releaseGrant)
                rrPtr <= (grant == SRC_W'(N_REQ - 1)) ? '0 : grant + SRC_W'(1);
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= ham_encode(grantData);
                out_src   <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule
